// File: rtl/icache_pkg.sv
// Shared definitions for the L1 instruction-cache refill path: geometry,
// fill-FSM state encoding and the line-address type used by fetch and fill.
package icache_pkg;

    localparam int BLOCK_BITS   = 256;
    localparam int BEAT_BITS    = 64;
    localparam int BEATS        = BLOCK_BITS / BEAT_BITS;
    localparam int LINE_ADDR_W  = 8;
    localparam int DRAIN_CYCLES = 2;

    localparam int BEAT_CNT_W  = $clog2(BEATS);
    localparam int DRAIN_CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef logic [LINE_ADDR_W-1:0] line_addr_t;
    typedef logic [BLOCK_BITS-1:0]  block_t;
    typedef logic [BEAT_BITS-1:0]   beat_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_BEAT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DRAIN = 3'd4
    } fill_state_t;

    // Line indices are compared bitwise only; there is no address arithmetic.
    function automatic logic addr_match(input line_addr_t a, input line_addr_t b);
        return a == b;
    endfunction

endpackage

// File: rtl/icache_beat_assembler.sv
// Collects BEATS memory beats into one cache line, beat 0 least significant,
// and flags the beat that completes the line.
module icache_beat_assembler
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  beat_valid_i,
    input  logic [BEAT_BITS-1:0]  beat_data_i,
    output logic [BLOCK_BITS-1:0] block_o,
    output logic                  last_beat_o
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

    logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
    block_t                buf_q, buf_d;

    // NOTE: every variable gets its default at the top of always_comb, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (beat_valid_i) begin
            buf_d[int'(cnt_q)*BEAT_BITS +: BEAT_BITS] = beat_data_i;
            cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
        end
    end

    assign last_beat_o = beat_valid_i && (cnt_q == LAST_BEAT);
    assign block_o     = buf_q;

    // NOTE: the wide line buffer is reset on purpose so the write-block output
    // reads as 0 out of reset; datapath storage is normally left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache refill sequencer: request/ack, beat assembly, one-cycle
// cache write, pipeline drain, plus a 1-entry coalescing pending slot.
module icache_fill_ctrl
    import icache_pkg::*;
(
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   fillReq_i,
    input  logic [LINE_ADDR_W-1:0] fillAddr_i,
    output logic                   fillReady_o,
    output logic                   fillBusy_o,
    output logic                   fillDone_o,
    output logic                   memReq_o,
    output logic [LINE_ADDR_W-1:0] memAddr_o,
    input  logic                   memAck_i,
    input  logic                   memValid_i,
    input  logic [BEAT_BITS-1:0]   memData_i,
    output logic                   writeEnable_o,
    output logic [LINE_ADDR_W-1:0] writeAddress_o,
    output logic [BLOCK_BITS-1:0]  writeBlock_o,
    output logic                   fetchStall_o
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    fill_state_t           state_q, state_d;
    line_addr_t            active_addr_q, active_addr_d;
    logic                  pend_valid_q, pend_valid_d;
    line_addr_t            pend_addr_q, pend_addr_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    line_addr_t            wr_addr_q, wr_addr_d;
    block_t                wr_block_q, wr_block_d;

    logic   accept;
    logic   coalesce;
    logic   asm_start;
    logic   asm_beat;
    logic   asm_last;
    block_t asm_block;

    assign accept   = fillReq_i && !pend_valid_q;
    assign coalesce = ((state_q != ST_IDLE) && addr_match(fillAddr_i, active_addr_q))
                   || (pend_valid_q && addr_match(fillAddr_i, pend_addr_q));

    assign asm_start = (state_q == ST_REQ) && memAck_i;
    assign asm_beat  = (state_q == ST_BEAT) && memValid_i;

    icache_beat_assembler u_assembler (
        .clk          (clock_i),
        .rst_n        (reset_i),
        .start_i      (asm_start),
        .beat_valid_i (asm_beat),
        .beat_data_i  (memData_i),
        .block_o      (asm_block),
        .last_beat_o  (asm_last)
    );

    always_comb begin
        state_d       = state_q;
        active_addr_d = active_addr_q;
        pend_valid_d  = pend_valid_q;
        pend_addr_d   = pend_addr_q;
        drain_cnt_d   = drain_cnt_q;
        wr_addr_d     = wr_addr_q;
        wr_block_d    = wr_block_q;

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    active_addr_d = pend_addr_q;
                    pend_valid_d  = 1'b0;
                    state_d       = ST_REQ;
                end else if (accept) begin
                    active_addr_d = fillAddr_i;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                if (memAck_i) state_d = ST_BEAT;
            end
            ST_BEAT: begin
                if (asm_last) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr_addr_d   = active_addr_q;
                wr_block_d  = asm_block;
                drain_cnt_d = '0;
                state_d     = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) state_d = ST_IDLE;
                else                           drain_cnt_d = drain_cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // A miss arriving behind an active fill queues unless it is a duplicate.
        if ((state_q != ST_IDLE) && accept && !coalesce) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = fillAddr_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, regardless of statement order.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= ST_IDLE;
            active_addr_q <= '0;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            drain_cnt_q   <= '0;
            wr_addr_q     <= '0;
            wr_block_q    <= '0;
        end else begin
            state_q       <= state_d;
            active_addr_q <= active_addr_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            drain_cnt_q   <= drain_cnt_d;
            wr_addr_q     <= wr_addr_d;
            wr_block_q    <= wr_block_d;
        end
    end

    assign fillReady_o    = !pend_valid_q;
    assign fillBusy_o     = (state_q != ST_IDLE) || pend_valid_q;
    assign fillDone_o     = (state_q == ST_DRAIN) && (drain_cnt_q == DRAIN_LAST);
    assign fetchStall_o   = (state_q != ST_IDLE);
    assign memReq_o       = (state_q == ST_REQ);
    assign memAddr_o      = memReq_o ? active_addr_q : '0;
    assign writeEnable_o  = (state_q == ST_WRITE);
    // Outside the write cycle the cache port keeps showing the last line written.
    assign writeAddress_o = writeEnable_o ? active_addr_q : wr_addr_q;
    assign writeBlock_o   = writeEnable_o ? asm_block     : wr_block_q;

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Refill sequencer for the L1 instruction-cache fetch stage.
- Accepts line-fill requests, fetches a 256-bit block from the memory side as four 64-bit beats, and assembles it.
- Drives the cache write port (write enable, 8-bit line address, 256-bit block) for one cycle.
- Holds fetch stalled until the cache's two-stage registered pipeline has drained.
- Has a 1-entry pending slot, so a second miss can queue behind the fill in flight.

Parameters:
BLOCK_BITS, 256, cache line width in bits
BEAT_BITS, 64, memory data bus width; BLOCK_BITS/BEAT_BITS = BEATS
BEATS, 4, beats per line; beat counter width = clog2(BEATS)
LINE_ADDR_W, 8, cache line index width
DRAIN_CYCLES, 2, cycles held after write so the registered write and output stages settle

Ports:
clock_i  in  1  clock, rising edge
reset_i  in  1  asynchronous, active-low reset
fillReq_i  in  1  fill request valid
fillAddr_i  in  LINE_ADDR_W  line index to fill
fillReady_o  out  1  request can be accepted; a request is accepted when fillReq_i & fillReady_o
fillBusy_o  out  1  a fill is active or pending
fillDone_o  out  1  one-cycle pulse: fill complete
memReq_o  out  1  memory read request
memAddr_o  out  LINE_ADDR_W  line index being read
memAck_i  in  1  memory accepted request
memValid_i  in  1  beat valid
memData_i  in  BEAT_BITS  beat data
writeEnable_o  out  1  cache write strobe
writeAddress_o  out  LINE_ADDR_W  cache write line
writeBlock_o  out  BLOCK_BITS  cache write data
fetchStall_o  out  1  fetch must hold its block address

Behaviour:
- Reset: reset_i low asynchronously clears all state.
  - State = IDLE; pending slot, beat counter and assembly buffer cleared.
  - All outputs 0, except fillReady_o = 1.
  - Reset mid-fill abandons the fill; no partial line is ever written.
- FSM states: IDLE, REQ, BEAT, WRITE, DRAIN.
- IDLE:
  - Pending valid: load its address as active, clear pending, go to REQ.
  - Otherwise, on an accepted request: load fillAddr_i as active, go to REQ.
- REQ:
  - memReq_o = 1 and memAddr_o = active address, held stable until memAck_i is sampled high; then go to BEAT with counter = 0.
  - memAck_i in any other state is ignored.
- BEAT:
  - Each sampled memValid_i writes memData_i into bits [BEAT_BITS*k +: BEAT_BITS] of the buffer, k = counter; beat 0 is least significant.
  - Counter increments per beat. The beat with k = BEATS-1 moves to WRITE; the counter wraps to 0.
  - Gaps between beats are allowed (no timeout).
  - memValid_i outside BEAT is ignored.
- WRITE (exactly 1 cycle):
  - writeEnable_o = 1, writeAddress_o = active address, writeBlock_o = assembled buffer.
  - Next state DRAIN.
  - In all other states writeEnable_o = 0 and address/block outputs hold their last values.
- DRAIN:
  - Lasts DRAIN_CYCLES cycles.
  - On its final cycle fillDone_o = 1, then go to IDLE.
  - The IDLE visit costs one cycle before a pending fill starts.
- Stall and status:
  - fetchStall_o = (state != IDLE); registered output, asserted from the cycle after acceptance.
  - fillBusy_o = (state != IDLE) | pendingValid.
- Pending slot / request acceptance:
  - fillReady_o = !pendingValid.
  - Request accepted while not in IDLE: stored in the pending slot.
  - Request accepted in IDLE with the slot empty: starts directly; the slot stays empty.
- Coalescing: an accepted request is dropped (still accepted, no new fill) if its address equals either:
  - the active address while state != IDLE, or
  - the valid pending address.
- Simultaneous events:
  - Request accepted in the same cycle that DRAIN completes: it goes into the pending slot, except when it coalesces with the active address.
  - Request arriving while the slot is full is not accepted; the requester holds fillReq_i.
- Widths: all addresses are LINE_ADDR_W bits, compared bitwise; no arithmetic on addresses.

Decomposition:
- Shared package icache_pkg holds:
  - BLOCK_BITS, BEAT_BITS, BEATS, LINE_ADDR_W;
  - fill FSM state encoding (3-bit enum: IDLE=0, REQ=1, BEAT=2, WRITE=3, DRAIN=4);
  - line-address typedef, shared with the fetch stage's 8-bit write address.
- One natural sub-module: icache_beat_assembler, holding the beat counter, the shift-in buffer, and a last-beat flag.
- Queue/coalesce logic and the FSM stay in the top module.

Test Plan:
- Basic fill:
  - Stimulus: reset, fillReq_i=1 with addr 0x05; memAck_i after 2 cycles; beats 0x1111..., 0x2222..., 0x3333..., 0x4444... on consecutive cycles.
  - Response: one writeEnable_o pulse, writeAddress_o=0x05, writeBlock_o = {0x4444...,0x3333...,0x2222...,0x1111...}.
  - Response: fillDone_o exactly 2 cycles after the write; fetchStall_o low the cycle after.
- Beat gaps: beats separated by 0, 3, 1 idle cycles -> identical block written; no early WRITE.
- Queue:
  - Stimulus: request 0x10 is active and request 0x20 arrives during BEAT.
  - Response: 0x20 is accepted into the pending slot and fillReady_o drops.
  - Response: a third request 0x30 is refused until 0x10's DRAIN completes; 0x20 is then filled, with memAddr_o=0x20.
- Coalesce: request 0x10 repeated during its own fill, and 0x20 repeated while pending -> exactly two memReq_o handshakes and two cache writes in total.
- Reset mid-fill: reset_i low after beat 2 of addr 0x07 -> outputs immediately 0 (fillReady_o=1); no writeEnable_o ever for 0x07; a fresh request after reset completes normally.
- Stray inputs: memValid_i and memAck_i pulsed while in IDLE and DRAIN -> no state change, no buffer corruption (verified by the next fill's data).
